// File: rtl/madd_seq_ctrl.sv
// -----------------------------------------------------------------------------
// madd_seq_ctrl
//
// Time-multiplexed residual matrix adder. One LANES-wide lane-wise adder is
// reused over a (rows x DIMENTION) matrix add. Each cycle one beat (LANES
// elements) of both operand matrices is read, added with two's-complement
// wrap-around, and written back to the destination buffer two cycles later.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, abort, hold    job request (IDLE only), job cancel, beat-issue pause
//   cfg_rows              rows in job (1..ADDER_NUM), sampled with start
//   src1_base, src2_base,
//   dst_base              beat base addresses, sampled with start
//   busy                  high while a job is running or draining
//   done                  one-cycle pulse when a job completes
//   err                   one-cycle pulse when start carried a bad cfg_rows
//   rd_en, rd_addr1/2     source buffer read strobe and beat addresses
//   rdata1/2              source data, valid the cycle after rd_en
//   wr_en, wr_addr,
//   wr_data               destination write strobe, beat address, lane sums
// -----------------------------------------------------------------------------
module madd_seq_ctrl #(
    parameter int ADDER_NUM    = 128,
    parameter int DIMENTION    = 768,
    parameter int WIDTH_ADDEND = 32,
    parameter int WIDTH_SUM    = WIDTH_ADDEND,
    parameter int LANES        = 64,
    parameter int ADDR_W       = 11,
    parameter int ROW_W        = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          hold,
    input  logic [ROW_W-1:0]              cfg_rows,
    input  logic [ADDR_W-1:0]             src1_base,
    input  logic [ADDR_W-1:0]             src2_base,
    input  logic [ADDR_W-1:0]             dst_base,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic                          rd_en,
    output logic [ADDR_W-1:0]             rd_addr1,
    output logic [ADDR_W-1:0]             rd_addr2,
    input  logic [LANES*WIDTH_ADDEND-1:0] rdata1,
    input  logic [LANES*WIDTH_ADDEND-1:0] rdata2,
    output logic                          wr_en,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [LANES*WIDTH_SUM-1:0]    wr_data
);

    localparam int CHUNKS = DIMENTION / LANES;
    // Beat counter must hold the largest job length (ADDER_NUM*CHUNKS beats).
    localparam int CNT_W  = $clog2(ADDER_NUM * CHUNKS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             k_q, k_d;
    logic [CNT_W-1:0]             last_k_q, last_k_d;
    logic [ADDR_W-1:0]            src1_base_q, src1_base_d;
    logic [ADDR_W-1:0]            src2_base_q, src2_base_d;
    logic [ADDR_W-1:0]            dst_base_q, dst_base_d;
    logic                         err_q, err_d;

    logic                         vld_p0_q, vld_p0_d;
    logic [ADDR_W-1:0]            addr_p0_q, addr_p0_d;
    logic                         vld_p1_q, vld_p1_d;
    logic [ADDR_W-1:0]            addr_p1_q, addr_p1_d;
    logic [LANES*WIDTH_SUM-1:0]   sum_p1_q, sum_p1_d;

    logic                         cfg_ok;
    logic                         kill;

    // Signed lane add with plain two's-complement wrap: no saturation.
    function automatic logic signed [WIDTH_SUM-1:0] add_wrap(
        input logic signed [WIDTH_ADDEND-1:0] a,
        input logic signed [WIDTH_ADDEND-1:0] b
    );
        logic signed [WIDTH_SUM-1:0] ea;
        logic signed [WIDTH_SUM-1:0] eb;
        ea = WIDTH_SUM'(a);
        eb = WIDTH_SUM'(b);
        return ea + eb;
    endfunction

    assign cfg_ok = (cfg_rows != '0) &&
                    ({1'b0, cfg_rows} <= (ROW_W+1)'(ADDER_NUM));

    // Abort cancels everything in flight, including beats already read.
    assign kill = abort && ((state_q == S_RUN) || (state_q == S_DRAIN));

    // ------------------------------------------------------------------
    // Control FSM and beat issue
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        last_k_d    = last_k_q;
        src1_base_d = src1_base_q;
        src2_base_d = src2_base_q;
        dst_base_d  = dst_base_q;
        err_d       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        rd_en       = 1'b0;
        vld_p0_d    = 1'b0;
        addr_p0_d   = addr_p0_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (cfg_ok) begin
                        src1_base_d = src1_base;
                        src2_base_d = src2_base;
                        dst_base_d  = dst_base;
                        k_d         = '0;
                        last_k_d    = CNT_W'(cfg_rows) * CNT_W'(CHUNKS) - CNT_W'(1);
                        state_d     = S_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_RUN: begin
                busy  = 1'b1;
                rd_en = !hold;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!hold) begin
                    vld_p0_d  = 1'b1;
                    addr_p0_d = dst_base_q + ADDR_W'(k_q);
                    k_d       = k_q + CNT_W'(1);
                    if (k_q == last_k_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (!vld_p0_q) begin
                    // Only the final write is left in stage 1: it issues now.
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stage p0 -> p1: read data arrives, lane-wise sum is registered
    // ------------------------------------------------------------------
    always_comb begin
        vld_p1_d  = vld_p0_q && !kill;
        addr_p1_d = addr_p0_q;
        sum_p1_d  = sum_p1_q;
        if (vld_p0_q) begin
            for (int j = 0; j < LANES; j++) begin
                sum_p1_d[j*WIDTH_SUM +: WIDTH_SUM] =
                    add_wrap(rdata1[j*WIDTH_ADDEND +: WIDTH_ADDEND],
                             rdata2[j*WIDTH_ADDEND +: WIDTH_ADDEND]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            last_k_q    <= '0;
            src1_base_q <= '0;
            src2_base_q <= '0;
            dst_base_q  <= '0;
            err_q       <= 1'b0;
            vld_p0_q    <= 1'b0;
            addr_p0_q   <= '0;
            vld_p1_q    <= 1'b0;
            addr_p1_q   <= '0;
            sum_p1_q    <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            last_k_q    <= last_k_d;
            src1_base_q <= src1_base_d;
            src2_base_q <= src2_base_d;
            dst_base_q  <= dst_base_d;
            err_q       <= err_d;
            vld_p0_q    <= vld_p0_d && !kill;
            addr_p0_q   <= addr_p0_d;
            vld_p1_q    <= vld_p1_d;
            addr_p1_q   <= addr_p1_d;
            sum_p1_q    <= sum_p1_d;
        end
    end

    assign rd_addr1 = src1_base_q + ADDR_W'(k_q);
    assign rd_addr2 = src2_base_q + ADDR_W'(k_q);
    assign err      = err_q;
    assign wr_en    = vld_p1_q;
    assign wr_addr  = addr_p1_q;
    assign wr_data  = sum_p1_q;

endmodule

// File: tb/tb_madd_seq_ctrl.sv
module tb_madd_seq_ctrl;

    localparam int LANES = 64;
    localparam int W     = 32;
    localparam int BUS   = LANES * W;
    localparam int CHUNKS = 12;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start, abort, hold;
    logic [7:0]      cfg_rows;
    logic [10:0]     src1_base, src2_base, dst_base;
    logic            busy, done, err, rd_en, wr_en;
    logic [10:0]     rd_addr1, rd_addr2, wr_addr;
    logic [BUS-1:0]  rdata1, rdata2, wr_data;

    int total = 0;
    int bad   = 0;
    int pat_sel = 0;

    madd_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold(hold),
        .cfg_rows(cfg_rows), .src1_base(src1_base), .src2_base(src2_base),
        .dst_base(dst_base), .busy(busy), .done(done), .err(err),
        .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rdata1(rdata1), .rdata2(rdata2), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [10:0] a, input int j,
                                        input int sel, input bit second);
        case (sel)
            0:       return 32'(j);
            1:       return second ? 32'd1 : 32'h7FFF_FFFF;
            default: return (32'(a) * 32'h9E37_79B1) ^ (32'(j) * 32'h85EB_CA6B) ^
                            (second ? 32'h5A5A_1234 : 32'h0F0F_00FF);
        endcase
    endfunction

    function automatic logic [BUS-1:0] exp_sum(input logic [10:0] a1,
                                               input logic [10:0] a2, input int sel);
        logic [BUS-1:0] v;
        for (int j = 0; j < LANES; j++)
            v[j*W +: W] = pat(a1, j, sel, 1'b0) + pat(a2, j, sel, 1'b1);
        return v;
    endfunction

    // Source buffers: one-cycle read latency; garbage when not read.
    always @(posedge clk) begin
        for (int j = 0; j < LANES; j++) begin
            rdata1[j*W +: W] <= rd_en ? pat(rd_addr1, j, pat_sel, 1'b0) : 32'hDEAD_BEEF;
            rdata2[j*W +: W] <= rd_en ? pat(rd_addr2, j, pat_sel, 1'b1) : 32'hBAAD_F00D;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_data(input string nm, input logic [BUS-1:0] act,
                            input logic [BUS-1:0] exp);
        int ln;
        total++;
        if (act !== exp) begin
            bad++;
            ln = 0;
            for (int j = LANES - 1; j >= 0; j--)
                if (act[j*W +: W] !== exp[j*W +: W]) ln = j;
            $display("FAIL %s: lane %0d got %h expected %h", nm, ln,
                     act[ln*W +: W], exp[ln*W +: W]);
        end
    endtask

    typedef struct {
        int rows;
        int b1, b2, bd;
        int sel;
        int h0, h1;      // hold window (0 = none)
        int ab;          // abort cycle (0 = none)
        int sb;          // cycle of a start issued while busy (0 = none)
        int exp_done;    // cycle of done pulse (0 = never)
    } job_t;

    job_t jobs[6];

    task automatic run_job(input job_t v);
        bit          rd_hist[0:2047];
        int          n, issued, wrc, last_rd, done_cyc, limit;
        bit          aborted, exp_rd, exp_wr, exp_done, exp_busy;
        logic [10:0] ea1, ea2, ed;
        rd_hist = '{default: 1'b0};
        n = v.rows * CHUNKS;
        issued = 0; wrc = 0; last_rd = 0; done_cyc = 0;
        limit = (v.ab != 0) ? v.ab + 6 : n + 12 + ((v.h0 != 0) ? v.h1 - v.h0 + 1 : 0);
        @(negedge clk);
        pat_sel   = v.sel;
        start     = 1'b1;
        cfg_rows  = 8'(v.rows);
        src1_base = 11'(v.b1);
        src2_base = 11'(v.b2);
        dst_base  = 11'(v.bd);
        @(posedge clk);
        for (int c = 1; c <= limit; c++) begin
            #1;
            start = (c == v.sb);
            if (c == v.sb) begin
                cfg_rows = 8'd1; src1_base = 11'd0; src2_base = 11'd0; dst_base = 11'd0;
            end
            hold  = (v.h0 != 0) && (c >= v.h0) && (c <= v.h1);
            abort = (c == v.ab);
            @(negedge clk);
            aborted = (v.ab != 0) && (c > v.ab);
            exp_rd  = !aborted && (issued < n) && !hold;
            chk("rd_en", rd_en, exp_rd);
            if (exp_rd) begin
                ea1 = 11'(v.b1 + issued);
                ea2 = 11'(v.b2 + issued);
                chk("rd_addr1", rd_addr1, ea1);
                chk("rd_addr2", rd_addr2, ea2);
                rd_hist[c] = 1'b1;
                issued++;
                if (issued == n) last_rd = c;
            end
            exp_wr = !aborted && (c >= 3) && rd_hist[c-2];
            chk("wr_en", wr_en, exp_wr);
            if (exp_wr && wr_en) begin
                ed  = 11'(v.bd + wrc);
                ea1 = 11'(v.b1 + wrc);
                ea2 = 11'(v.b2 + wrc);
                chk("wr_addr", wr_addr, ed);
                chk_data("wr_data", wr_data, exp_sum(ea1, ea2, v.sel));
            end
            if (exp_wr) wrc++;
            exp_done = (v.ab == 0) && (last_rd > 0) && (c == last_rd + 3);
            chk("done", done, exp_done);
            exp_busy = (v.ab != 0) ? (c <= v.ab) : !((last_rd > 0) && (c >= last_rd + 3));
            chk("busy", busy, exp_busy);
            chk("err_in_job", err, 1'b0);
            if (done && done_cyc == 0) done_cyc = c;
            @(posedge clk);
        end
        #1;
        start = 1'b0; hold = 1'b0; abort = 1'b0;
        chk("done_cycle", done_cyc, v.exp_done);
        chk("write_count", wrc, (v.ab != 0) ? v.ab - 2 : n);
    endtask

    task automatic bad_cfg(input int rows);
        @(negedge clk);
        start = 1'b1;
        cfg_rows = 8'(rows);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("err_pulse", err, 1'b1);
        chk("err_busy", busy, 1'b0);
        chk("err_rd_en", rd_en, 1'b0);
        @(negedge clk);
        chk("err_clear", err, 1'b0);
        chk("err_busy2", busy, 1'b0);
        chk("err_rd_en2", rd_en, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0;
        cfg_rows = '0; src1_base = '0; src2_base = '0; dst_base = '0;

        jobs[0] = '{rows: 1,   b1: 0,    b2: 0,   bd: 0,   sel: 0, h0: 0,  h1: 0,  ab: 0,   sb: 0,  exp_done: 15};
        jobs[1] = '{rows: 128, b1: 0,    b2: 0,   bd: 0,   sel: 1, h0: 0,  h1: 0,  ab: 0,   sb: 0,  exp_done: 1539};
        jobs[2] = '{rows: 8,   b1: 100,  b2: 300, bd: 500, sel: 2, h0: 50, h1: 54, ab: 0,   sb: 20, exp_done: 104};
        jobs[3] = '{rows: 128, b1: 10,   b2: 20,  bd: 30,  sel: 2, h0: 0,  h1: 0,  ab: 100, sb: 0,  exp_done: 0};
        jobs[4] = '{rows: 2,   b1: 5,    b2: 6,   bd: 7,   sel: 2, h0: 0,  h1: 0,  ab: 0,   sb: 0,  exp_done: 27};
        jobs[5] = '{rows: 1,   b1: 2040, b2: 0,   bd: 0,   sel: 2, h0: 0,  h1: 0,  ab: 0,   sb: 0,  exp_done: 15};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_rd_addr1", rd_addr1, 11'd0);
        chk("rst_rd_addr2", rd_addr2, 11'd0);
        chk("rst_wr_addr", wr_addr, 11'd0);
        chk_data("rst_wr_data", wr_data, '0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_job(jobs[i]);

        bad_cfg(0);
        bad_cfg(129);

        // abort together with start in IDLE: start is dropped
        @(negedge clk);
        start = 1'b1; abort = 1'b1; cfg_rows = 8'd2;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abst_busy", busy, 1'b0);
            chk("abst_rd_en", rd_en, 1'b0);
            chk("abst_err", err, 1'b0);
        end

        // reset in the middle of a job
        @(negedge clk);
        start = 1'b1; cfg_rows = 8'd2;
        src1_base = 11'd3; src2_base = 11'd4; dst_base = 11'd9;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_rd_en", rd_en, 1'b0);
        chk("mrst_wr_en", wr_en, 1'b0);
        chk("mrst_rd_addr1", rd_addr1, 11'd0);
        chk("mrst_wr_addr", wr_addr, 11'd0);
        chk_data("mrst_wr_data", wr_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_busy", busy, 1'b0);
            chk("post_rst_wr_en", wr_en, 1'b0);
            chk("post_rst_done", done, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
